// File: rtl/lcd_bus_responder.sv
// Purpose : HD44780-style LCD module model answering the MIPS LCD bus (DATA/RW/EN/RS/ON);
//           latches transfers on EN falling edge, keeps an 80-byte DDRAM, AC, entry mode, busy flag.
// Latency : commands take effect at the clk edge that sees EN fall; read data is registered one cycle.
// Backpr. : BUSY is the only flow control; writes/data reads arriving while BUSY=1 are dropped
//           and flagged on the sticky PROTO_ERR.
// Ports   : clk, rst (sync, active-low), ON (0 = reset), EN/RS/RW/DATA_IN bus inputs,
//           DATA_OUT/DATA_OE read drive, BUSY, PROTO_ERR, DISP_ON, CURSOR_ADDR (AC),
//           PEEK_ADDR/PEEK_DATA combinational DDRAM observation port.
module lcd_bus_responder #(
    parameter int BUSY_CYCLES  = 37,
    parameter int CLEAR_CYCLES = 1520
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ON,
    input  logic       EN,
    input  logic       RS,
    input  logic       RW,
    input  logic [7:0] DATA_IN,
    output logic [7:0] DATA_OUT,
    output logic       DATA_OE,
    output logic       BUSY,
    output logic       PROTO_ERR,
    output logic       DISP_ON,
    output logic [6:0] CURSOR_ADDR,
    input  logic [6:0] PEEK_ADDR,
    output logic [7:0] PEEK_DATA
);

    localparam int              MAX_CYC    = (BUSY_CYCLES > CLEAR_CYCLES) ? BUSY_CYCLES : CLEAR_CYCLES;
    localparam int              CW         = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0]   BUSY_LOAD  = CW'(BUSY_CYCLES);
    localparam logic [CW-1:0]   CLEAR_LOAD = CW'(CLEAR_CYCLES);
    localparam logic [7:0]      BLANK      = 8'h20;

    // Columns 0..39 exist on each of the two lines; bit 6 selects the line.
    function automatic logic addr_valid(input logic [5:0] col);
        return col < 6'd40;
    endfunction

    function automatic logic [6:0] addr_idx(input logic [6:0] a);
        return a[6] ? ({1'b0, a[5:0]} + 7'd40) : {1'b0, a[5:0]};
    endfunction

    // Line-wrapping step; addresses off the valid map fall through to plain +/-1 mod 128.
    function automatic logic [6:0] addr_step(input logic [6:0] a, input logic inc);
        logic [6:0] n;
        if (inc) begin
            if (a == 7'h27)      n = 7'h40;
            else if (a == 7'h67) n = 7'h00;
            else                 n = a + 7'd1;
        end else begin
            if (a == 7'h00)      n = 7'h67;
            else if (a == 7'h40) n = 7'h27;
            else                 n = a - 7'd1;
        end
        return n;
    endfunction

    logic [7:0]    r_ddram [0:79];
    logic          r_en_q;
    logic [7:0]    r_data_q;
    logic [7:0]    r_dout;
    logic          r_oe;
    logic [CW-1:0] r_busy_cnt;
    logic          r_perr;
    logic [6:0]    r_ac;
    logic          r_id;
    // Cursor, blink and shift bits are not stored: nothing in this model observes them.
    logic          r_disp;

    logic          w_strobe;
    logic          w_busy;
    logic          w_ac_valid;
    logic [6:0]    w_ac_idx;
    logic [7:0]    w_rd_data;
    logic          w_peek_valid;
    logic [6:0]    w_peek_idx;

    assign w_strobe     = r_en_q & ~EN;
    assign w_busy       = (r_busy_cnt != '0);
    assign w_ac_valid   = addr_valid(r_ac[5:0]);
    assign w_ac_idx     = addr_idx(r_ac);
    assign w_rd_data    = w_ac_valid ? r_ddram[w_ac_idx] : BLANK;
    assign w_peek_valid = addr_valid(PEEK_ADDR[5:0]);
    assign w_peek_idx   = addr_idx(PEEK_ADDR);

    always_ff @(posedge clk) begin
        if (!rst || !ON) begin
            r_en_q     <= 1'b0;
            r_data_q   <= 8'h00;
            r_dout     <= 8'h00;
            r_oe       <= 1'b0;
            r_busy_cnt <= '0;
            r_perr     <= 1'b0;
            r_ac       <= 7'h00;
            r_id       <= 1'b1;
            r_disp     <= 1'b0;
            for (int i = 0; i < 80; i++) r_ddram[i] <= BLANK;
        end else begin
            r_en_q <= EN;
            if (EN) r_data_q <= DATA_IN;
            r_oe <= EN & RW;
            if (EN && RW) r_dout <= RS ? w_rd_data : {w_busy, r_ac};
            if (w_busy) r_busy_cnt <= r_busy_cnt - CW'(1);

            // Status reads (RS=0, RW=1) never touch state, so they skip this whole block.
            if (w_strobe && !(RW && !RS)) begin
                if (w_busy) begin
                    r_perr <= 1'b1;
                end else if (RS) begin
                    if (!RW && w_ac_valid) r_ddram[w_ac_idx] <= r_data_q;
                    r_ac       <= addr_step(r_ac, r_id);
                    r_busy_cnt <= BUSY_LOAD;
                end else begin
                    // Highest set bit picks the instruction.
                    casez (r_data_q)
                        8'b1???????: begin
                            r_ac       <= r_data_q[6:0];
                            r_busy_cnt <= BUSY_LOAD;
                        end
                        8'b01??????,
                        8'b001?????: r_busy_cnt <= BUSY_LOAD;
                        8'b0001????: begin
                            if (!r_data_q[3]) r_ac <= addr_step(r_ac, r_data_q[2]);
                            r_busy_cnt <= BUSY_LOAD;
                        end
                        8'b00001???: begin
                            r_disp     <= r_data_q[2];
                            r_busy_cnt <= BUSY_LOAD;
                        end
                        8'b000001??: begin
                            r_id       <= r_data_q[1];
                            r_busy_cnt <= BUSY_LOAD;
                        end
                        8'b0000001?: begin
                            r_ac       <= 7'h00;
                            r_busy_cnt <= CLEAR_LOAD;
                        end
                        8'b00000001: begin
                            for (int i = 0; i < 80; i++) r_ddram[i] <= BLANK;
                            r_ac       <= 7'h00;
                            r_id       <= 1'b1;
                            r_busy_cnt <= CLEAR_LOAD;
                        end
                        default: ; // 0x00: no operation, no busy
                    endcase
                end
            end
        end
    end

    assign DATA_OUT    = r_dout;
    assign DATA_OE     = r_oe;
    assign BUSY        = w_busy;
    assign PROTO_ERR   = r_perr;
    assign DISP_ON     = r_disp;
    assign CURSOR_ADDR = r_ac;
    assign PEEK_DATA   = w_peek_valid ? r_ddram[w_peek_idx] : BLANK;

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Purpose : self-checking bench for lcd_bus_responder against a behavioural LCD model.
// Latency : bus transfers take three clk cycles from EN rise to the strobe edge.
// Backpr. : the bench waits out BUSY using the model's predicted busy window.
module tb_lcd_bus_responder;

    localparam int BC = 37;
    localparam int CC = 1520;

    logic       clk = 1'b0;
    logic       rst, ON, EN, RS, RW;
    logic [7:0] DATA_IN, DATA_OUT, PEEK_DATA;
    logic       DATA_OE, BUSY, PROTO_ERR, DISP_ON;
    logic [6:0] CURSOR_ADDR, PEEK_ADDR;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lcd_bus_responder #(.BUSY_CYCLES(BC), .CLEAR_CYCLES(CC)) dut (
        .clk(clk), .rst(rst), .ON(ON), .EN(EN), .RS(RS), .RW(RW),
        .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT), .DATA_OE(DATA_OE), .BUSY(BUSY),
        .PROTO_ERR(PROTO_ERR), .DISP_ON(DISP_ON), .CURSOR_ADDR(CURSOR_ADDR),
        .PEEK_ADDR(PEEK_ADDR), .PEEK_DATA(PEEK_DATA)
    );

    // ---------------- behavioural model ----------------
    logic [7:0] m_ram [80];
    logic [6:0] m_ac;
    bit         m_id, m_disp, m_perr;
    int         m_busy_end;   // BUSY is 1 at samples where cyc < m_busy_end

    function automatic int m_idx(input logic [6:0] a);
        int line, col;
        line = int'(a) / 64;
        col  = int'(a) % 64;
        return (col < 40) ? line * 40 + col : -1;
    endfunction

    // Walk the 80 display positions as one ring; off-map addresses just count mod 128.
    function automatic logic [6:0] m_step(input logic [6:0] a, input bit inc);
        int p;
        p = m_idx(a);
        if (p < 0) return inc ? 7'(int'(a) + 1) : 7'(int'(a) + 127);
        p = inc ? (p + 1) % 80 : (p + 79) % 80;
        return (p < 40) ? 7'(p) : 7'(p + 24);
    endfunction

    function automatic logic [7:0] m_peek(input logic [6:0] a);
        int p;
        p = m_idx(a);
        return (p < 0) ? 8'h20 : m_ram[p];
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < 80; i++) m_ram[i] = 8'h20;
        m_ac = 7'h00; m_id = 1'b1; m_disp = 1'b0; m_perr = 1'b0; m_busy_end = 0;
    endfunction

    // c = cyc at the sample right after the last EN=1 edge
    function automatic logic [7:0] m_read(input bit rs, input int c);
        if (rs) return m_peek(m_ac);
        return {((c - 1) < m_busy_end) ? 1'b1 : 1'b0, m_ac};
    endfunction

    // s = cyc at the sample right after the strobe edge
    function automatic void m_strobe(input bit rs, input bit rw, input logic [7:0] d, input int s);
        int n, p;
        n = 0;
        if (!rs && rw) return;
        if ((s - 1) < m_busy_end) begin
            m_perr = 1'b1;
            return;
        end
        if (rs) begin
            p = m_idx(m_ac);
            if (!rw && p >= 0) m_ram[p] = d;
            m_ac = m_step(m_ac, m_id);
            n = BC;
        end else if (d >= 8'h80) begin
            m_ac = d[6:0]; n = BC;
        end else if (d >= 8'h20) begin
            n = BC;
        end else if (d >= 8'h10) begin
            if (!d[3]) m_ac = m_step(m_ac, d[2]);
            n = BC;
        end else if (d >= 8'h08) begin
            m_disp = d[2]; n = BC;
        end else if (d >= 8'h04) begin
            m_id = d[1]; n = BC;
        end else if (d >= 8'h02) begin
            m_ac = 7'h00; n = CC;
        end else if (d == 8'h01) begin
            for (int i = 0; i < 80; i++) m_ram[i] = 8'h20;
            m_ac = 7'h00; m_id = 1'b1; n = CC;
        end
        if (n > 0) m_busy_end = s + n;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic bus_cycle(input bit rs, input bit rw, input logic [7:0] d,
                             output logic [7:0] rd, output logic oe, output logic [7:0] ex);
        @(posedge clk); #1;
        RS = rs; RW = rw; DATA_IN = d; EN = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rd = DATA_OUT; oe = DATA_OE; ex = m_read(rs, cyc);
        EN = 1'b0;
        DATA_IN = 8'($urandom);   // writes must use the byte latched while EN was high
        @(posedge clk); #1;
        m_strobe(rs, rw, d, cyc);
    endtask

    task automatic wait_idle(output int bad);
        bad = 0;
        while (cyc < m_busy_end) begin
            if (BUSY !== 1'b1) bad++;
            @(posedge clk); #1;
        end
        if (BUSY !== 1'b0) bad++;
    endtask

    task automatic peek_sweep(output int bad);
        bad = 0;
        for (int a = 0; a < 128; a++) begin
            PEEK_ADDR = 7'(a); #1;
            if (PEEK_DATA !== m_peek(7'(a))) bad++;
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input bit use_on);
        @(posedge clk); #1;
        if (use_on) ON = 1'b0; else rst = 1'b0;
        @(posedge clk); #1;
        ON = 1'b1; rst = 1'b1;
        m_reset();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        logic [7:0] rd, ex; logic oe;
        // EN high across reset: the fall just after reset must not count as a strobe.
        @(posedge clk); #1;
        RS = 1'b1; RW = 1'b0; DATA_IN = 8'h77; EN = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1; rst = 1'b1; EN = 1'b0; m_reset();
        checks++; if (BUSY !== 1'b0)    begin failures++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
        checks++; if (DATA_OE !== 1'b0) begin failures++; $display("FAIL reset_oe got=%b exp=0", DATA_OE); end
        checks++; if (DATA_OUT !== 8'h00) begin failures++; $display("FAIL reset_dout got=%h exp=00", DATA_OUT); end
        checks++; if (PROTO_ERR !== 1'b0) begin failures++; $display("FAIL reset_perr got=%b exp=0", PROTO_ERR); end
        checks++; if (DISP_ON !== 1'b0) begin failures++; $display("FAIL reset_disp got=%b exp=0", DISP_ON); end
        @(posedge clk); #1;
        checks++; if (CURSOR_ADDR !== 7'h00 || BUSY !== 1'b0) begin failures++;
            $display("FAIL reset_no_strobe ac=%h busy=%b exp ac=00 busy=0", CURSOR_ADDR, BUSY); end
        bus_cycle(1'b0, 1'b1, 8'h00, rd, oe, ex);
        checks++; if (oe !== 1'b1) begin failures++; $display("FAIL status_oe got=%b exp=1", oe); end
        checks++; if (rd !== ex)   begin failures++; $display("FAIL status_read got=%h exp=%h", rd, ex); end
        checks++; if (DATA_OE !== 1'b0) begin failures++; $display("FAIL oe_release got=%b exp=0", DATA_OE); end
        PEEK_ADDR = 7'h05; #1;
        checks++; if (PEEK_DATA !== 8'h20) begin failures++; $display("FAIL reset_peek05 got=%h exp=20", PEEK_DATA); end
    endtask

    task automatic test_clear;
        logic [7:0] rd, ex; logic oe; int b;
        bus_cycle(1'b0, 1'b0, 8'h80, rd, oe, ex); wait_idle(b);
        for (int k = 0; k < 6; k++) begin
            bus_cycle(1'b1, 1'b0, 8'($urandom_range(33, 126)), rd, oe, ex); wait_idle(b);
        end
        bus_cycle(1'b0, 1'b0, 8'h01, rd, oe, ex);
        checks++; if (BUSY !== 1'b1) begin failures++; $display("FAIL clear_busy_start got=%b exp=1", BUSY); end
        repeat (100) begin @(posedge clk); #1; end
        bus_cycle(1'b0, 1'b1, 8'h00, rd, oe, ex);
        checks++; if (rd !== ex) begin failures++; $display("FAIL clear_mid_status got=%h exp=%h", rd, ex); end
        wait_idle(b);
        checks++; if (b !== 0) begin failures++; $display("FAIL clear_busy_len bad_cycles=%0d exp=0", b); end
        peek_sweep(b);
        checks++; if (b !== 0) begin failures++; $display("FAIL clear_peek bad=%0d exp=0", b); end
    endtask

    task automatic test_wrap;
        logic [7:0] rd, ex; logic oe; int b;
        bus_cycle(1'b0, 1'b0, 8'hA7, rd, oe, ex); wait_idle(b);
        bus_cycle(1'b1, 1'b0, 8'h41, rd, oe, ex); wait_idle(b);
        bus_cycle(1'b1, 1'b0, 8'h42, rd, oe, ex); wait_idle(b);
        PEEK_ADDR = 7'h27; #1;
        checks++; if (PEEK_DATA !== m_peek(7'h27)) begin failures++; $display("FAIL wrap_peek27 got=%h exp=%h", PEEK_DATA, m_peek(7'h27)); end
        PEEK_ADDR = 7'h40; #1;
        checks++; if (PEEK_DATA !== m_peek(7'h40)) begin failures++; $display("FAIL wrap_peek40 got=%h exp=%h", PEEK_DATA, m_peek(7'h40)); end
        checks++; if (CURSOR_ADDR !== m_ac) begin failures++; $display("FAIL wrap_ac got=%h exp=%h", CURSOR_ADDR, m_ac); end
    endtask

    task automatic test_read;
        logic [7:0] rd, ex; logic oe; int b;
        bus_cycle(1'b0, 1'b0, 8'hC0, rd, oe, ex); wait_idle(b);
        bus_cycle(1'b1, 1'b1, 8'h00, rd, oe, ex);
        checks++; if (oe !== 1'b1) begin failures++; $display("FAIL read_oe got=%b exp=1", oe); end
        checks++; if (rd !== ex)   begin failures++; $display("FAIL data_read got=%h exp=%h", rd, ex); end
        checks++; if (CURSOR_ADDR !== m_ac) begin failures++; $display("FAIL read_ac got=%h exp=%h", CURSOR_ADDR, m_ac); end
        checks++; if (BUSY !== 1'b1) begin failures++; $display("FAIL read_busy got=%b exp=1", BUSY); end
        wait_idle(b);
    endtask

    task automatic test_decrement;
        logic [7:0] rd, ex; logic oe; int b;
        bus_cycle(1'b0, 1'b0, 8'h04, rd, oe, ex); wait_idle(b);
        bus_cycle(1'b0, 1'b0, 8'h80, rd, oe, ex); wait_idle(b);
        bus_cycle(1'b1, 1'b0, 8'h55, rd, oe, ex); wait_idle(b);
        PEEK_ADDR = 7'h00; #1;
        checks++; if (PEEK_DATA !== m_peek(7'h00)) begin failures++; $display("FAIL dec_peek00 got=%h exp=%h", PEEK_DATA, m_peek(7'h00)); end
        checks++; if (CURSOR_ADDR !== m_ac) begin failures++; $display("FAIL dec_ac got=%h exp=%h", CURSOR_ADDR, m_ac); end
    endtask

    task automatic test_conflict;
        logic [7:0] rd, ex; logic oe; int b;
        bus_cycle(1'b1, 1'b0, 8'h99, rd, oe, ex);
        @(posedge clk); #1;
        bus_cycle(1'b1, 1'b0, 8'h3C, rd, oe, ex);   // strobe lands 5 cycles into busy
        checks++; if (PROTO_ERR !== 1'b1) begin failures++; $display("FAIL conflict_perr got=%b exp=1", PROTO_ERR); end
        checks++; if (CURSOR_ADDR !== m_ac) begin failures++; $display("FAIL conflict_ac got=%h exp=%h", CURSOR_ADDR, m_ac); end
        wait_idle(b);
        checks++; if (b !== 0) begin failures++; $display("FAIL conflict_no_reload bad_cycles=%0d exp=0", b); end
        peek_sweep(b);
        checks++; if (b !== 0) begin failures++; $display("FAIL conflict_peek bad=%0d exp=0", b); end
        bus_cycle(1'b0, 1'b0, 8'h0C, rd, oe, ex);
        repeat (3) begin @(posedge clk); #1; end
        do_reset(1'b0);   // lands mid-busy
        checks++; if (PROTO_ERR !== 1'b0 || BUSY !== 1'b0 || CURSOR_ADDR !== 7'h00 || DISP_ON !== 1'b0) begin failures++;
            $display("FAIL conflict_reset perr=%b busy=%b ac=%h disp=%b exp 0/0/00/0", PROTO_ERR, BUSY, CURSOR_ADDR, DISP_ON); end
    endtask

    task automatic test_random;
        logic [7:0] rd, ex, d; logic oe; int b, bad, op;
        bad = 0;
        for (int k = 0; k < 80; k++) begin
            op = int'($urandom_range(0, 9));
            d  = 8'($urandom);
            case (op)
                0, 1, 2, 3: bus_cycle(1'b1, 1'b0, d, rd, oe, ex);
                4, 5: begin
                    bus_cycle(op == 4, 1'b1, 8'h00, rd, oe, ex);
                    checks++; if (rd !== ex) begin failures++; $display("FAIL rand_read%0d op=%0d got=%h exp=%h", k, op, rd, ex); end
                end
                6: bus_cycle(1'b0, 1'b0, d, rd, oe, ex);
                7: bus_cycle(1'b0, 1'b0, {1'b1, d[6:0]}, rd, oe, ex);
                8: bus_cycle(1'b0, 1'b0, {4'h1, d[3:0]}, rd, oe, ex);
                default: bus_cycle(1'b0, 1'b0, {6'b000001, d[1:0]}, rd, oe, ex);
            endcase
            if ($urandom_range(0, 3) != 0) begin
                wait_idle(b); bad += b;
            end
        end
        wait_idle(b); bad += b;
        checks++; if (bad !== 0) begin failures++; $display("FAIL rand_busy bad_cycles=%0d exp=0", bad); end
        peek_sweep(b);
        checks++; if (b !== 0) begin failures++; $display("FAIL rand_peek bad=%0d exp=0", b); end
        checks++; if (CURSOR_ADDR !== m_ac) begin failures++; $display("FAIL rand_ac got=%h exp=%h", CURSOR_ADDR, m_ac); end
        checks++; if (DISP_ON !== m_disp) begin failures++; $display("FAIL rand_disp got=%b exp=%b", DISP_ON, m_disp); end
        checks++; if (PROTO_ERR !== m_perr) begin failures++; $display("FAIL rand_perr got=%b exp=%b", PROTO_ERR, m_perr); end
    endtask

    task automatic test_power_off;
        logic [7:0] rd, ex; logic oe; int b;
        bus_cycle(1'b0, 1'b0, 8'h0F, rd, oe, ex); wait_idle(b);
        bus_cycle(1'b1, 1'b0, 8'h5A, rd, oe, ex);
        do_reset(1'b1);
        checks++; if (BUSY !== 1'b0 || DATA_OE !== 1'b0 || DATA_OUT !== 8'h00 || PROTO_ERR !== 1'b0) begin failures++;
            $display("FAIL on_outputs busy=%b oe=%b dout=%h perr=%b exp 0/0/00/0", BUSY, DATA_OE, DATA_OUT, PROTO_ERR); end
        checks++; if (DISP_ON !== 1'b0 || CURSOR_ADDR !== 7'h00) begin failures++;
            $display("FAIL on_state disp=%b ac=%h exp 0/00", DISP_ON, CURSOR_ADDR); end
        peek_sweep(b);
        checks++; if (b !== 0) begin failures++; $display("FAIL on_peek bad=%0d exp=0", b); end
        bus_cycle(1'b1, 1'b0, 8'h31, rd, oe, ex); wait_idle(b);
        PEEK_ADDR = 7'h00; #1;   // I/D must be back to increment after power-off
        checks++; if (PEEK_DATA !== m_peek(7'h00) || CURSOR_ADDR !== m_ac) begin failures++;
            $display("FAIL on_after_write peek=%h ac=%h exp %h/%h", PEEK_DATA, CURSOR_ADDR, m_peek(7'h00), m_ac); end
    endtask

    initial begin
        rst = 1'b0; ON = 1'b1; EN = 1'b0; RS = 1'b0; RW = 1'b0;
        DATA_IN = 8'h00; PEEK_ADDR = 7'h00;
        m_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        test_reset();
        test_clear();
        test_wrap();
        test_read();
        test_decrement();
        test_conflict();
        test_random();
        test_power_off();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lcd_bus_responder.md
Name: lcd_bus_responder

Overview:
- Behavioural-synthesizable HD44780-style LCD module for the far end of the MIPS LCD bus (DATA, RW, EN, RS, ON).
- Latches commands and characters on EN falling edge and models the busy flag, address counter (AC), entry mode and display control.
- Holds an 80-byte DDRAM.
- Answers busy-flag/AC reads and data reads, so benches and FPGA loopback can check the controller end to end.

Parameters:
- BUSY_CYCLES, 37, clk cycles BUSY stays set after a normal command, data write or data read.
- CLEAR_CYCLES, 1520, clk cycles BUSY stays set after clear (0x01) or home (0x02/0x03).

Ports:
- clk, input, 1, system clock; all logic on rising edge.
- rst, input, 1, synchronous active-low reset.
- ON, input, 1, module power; 0 is treated exactly like rst=0.
- EN, input, 1, bus strobe; a transfer completes on the 1->0 transition.
- RS, input, 1, 0 = instruction/status, 1 = data.
- RW, input, 1, 0 = write, 1 = read.
- DATA_IN, input, 8, bus data driven by the controller.
- DATA_OUT, output, 8, read data.
- DATA_OE, output, 1, responder drives the bus.
- BUSY, output, 1, busy flag (BF).
- PROTO_ERR, output, 1, sticky; set when a write or data read is received while BUSY=1.
- DISP_ON, output, 1, display-control D bit.
- CURSOR_ADDR, output, 7, current AC.
- PEEK_ADDR, input, 7, DDRAM address for bench/debug observation.
- PEEK_DATA, output, 8, combinational DDRAM[map(PEEK_ADDR)]; 0x20 for invalid addresses.

Behaviour:
- Reset (rst=0 or ON=0, sampled at a clk edge) sets:
  - DATA_OUT=0, DATA_OE=0, BUSY=0, busy counter=0, PROTO_ERR=0.
  - AC=0, I/D=1, S=0, D=C=B=0, DISP_ON=0.
  - All 80 DDRAM bytes = 0x20.
  - en_q=0, so no strobe is detected in the cycle after reset.
  - Reset overrides any in-progress busy period.
- Strobe detection:
  - en_q registers EN every cycle; strobe = en_q & ~EN.
  - data_q captures DATA_IN every cycle EN=1; writes use data_q, not DATA_IN at the fall.
  - RS and RW are sampled at the strobe cycle.
- Read drive:
  - DATA_OE is registered: it goes 1 the cycle after EN=1 & RW=1 is seen and returns to 0 the cycle after EN falls or RW=0.
  - DATA_OUT is updated each cycle while EN=1 & RW=1:
    - RS=0: DATA_OUT = {BUSY, AC}.
    - RS=1: DATA_OUT = DDRAM[map(AC)].
- Address map:
  - Valid AC values are 0x00-0x27 (line 0) and 0x40-0x67 (line 1).
  - index = AC[6]*40 + AC[5:0].
  - Writes to invalid AC values are discarded; reads return 0x20.
- AC step (after a data write or data read):
  - I/D=1 increments: 0x27->0x40, 0x67->0x00.
  - I/D=0 decrements: 0x00->0x67, 0x40->0x27.
  - From an invalid AC value, AC steps by plain +/-1 mod 128.
- Instruction decode at a write strobe (RS=0, RW=0); the highest set bit of the byte selects the command:
  - 0x80-0xFF: AC = d[6:0].
  - 0x40-0x7F: CGRAM address; accepted and ignored except for BUSY.
  - 0x20-0x3F: function set; accepted, no state change.
  - 0x10-0x1F: d[3]=0 moves AC one step per d[2] (1 = increment) using the wrap rules; d[3]=1 (display shift) has no state change.
  - 0x08-0x0F: D=d[2], C=d[1], B=d[0].
  - 0x04-0x07: I/D=d[1], S=d[0].
  - 0x02-0x03: AC=0; busy for CLEAR_CYCLES.
  - 0x01: all DDRAM = 0x20 in the strobe cycle, AC=0, I/D=1; busy for CLEAR_CYCLES.
  - 0x00: no operation and no busy.
  - Every other accepted instruction sets busy for BUSY_CYCLES.
- Busy timing:
  - At the accepted strobe the counter loads N (BUSY_CYCLES or CLEAR_CYCLES) and BUSY=1 starting the next cycle.
  - The counter decrements each cycle; BUSY=0 in the cycle after the counter reaches 0, so BUSY is high for exactly N cycles.
- Busy conflicts:
  - A write or data-read strobe while BUSY=1 is ignored: no state change and no counter reload, and PROTO_ERR is set.
  - A status read (RS=0, RW=1) is always legal and has no side effects.
  - PROTO_ERR clears only on reset.
- Data write (RS=1, RW=0): DDRAM[map(AC)] = data_q, then AC steps; busy for BUSY_CYCLES.
- Data read (RS=1, RW=1): AC steps at the strobe; busy for BUSY_CYCLES.
- Simultaneous reset and strobe: reset wins and the strobe is lost.

Test Plan:
- Reset with rst=0 for 1 cycle, then status read (RS=0, RW=1, EN pulse) -> DATA_OE=1 during EN, DATA_OUT=0x00; DISP_ON=0; PEEK(0x05)=0x20.
- Write 0x01 with CLEAR_CYCLES=1520 -> BUSY high exactly 1520 cycles after the EN fall; a status read mid-period returns 0x80; every PEEK returns 0x20.
- Write 0xA7, then data 0x41, then data 0x42 -> PEEK(0x27)=0x41, PEEK(0x40)=0x42, CURSOR_ADDR=0x41.
- Write 0x04 (decrement), write 0x80, then data 0x55 -> PEEK(0x00)=0x55, CURSOR_ADDR=0x67.
- Data write issued 5 cycles after an accepted data write -> DDRAM and AC unchanged, PROTO_ERR=1; pulse rst=0 -> PROTO_ERR=0, BUSY=0, AC=0 on the next cycle.
- Write 0xC0, wait out busy, data read (RS=1, RW=1) after the 0x42 write above -> DATA_OUT=0x42, CURSOR_ADDR=0x41; ON=0 for 1 cycle -> full reset state.
